// File: rtl/tb_l2_mem_responder_if.sv
// Command encoding and request/response bundle for the L2 memory responder.
// master = requester side (loader/arbiter), slave = the responder.
package tb_l2_mem_responder_pkg;
  typedef enum logic [4:0] {
    M_XRD = 5'b00000,
    M_XWR = 5'b00001,
    M_PFR = 5'b00010,
    M_PFW = 5'b00011
  } mem_cmd_t;
endpackage

interface tb_l2_mem_responder_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
);
  logic                                   req_valid;
  tb_l2_mem_responder_pkg::mem_cmd_t      req_cmd;
  logic [ADDR_W-1:0]                      req_addr;
  logic [TAG_W-1:0]                       req_tag;
  logic [DATA_W-1:0]                      req_data;
  logic [DATA_W/8-1:0]                    req_byte_en;
  logic                                   req_ready;
  logic                                   resp_valid;
  logic [TAG_W-1:0]                       resp_tag;
  logic [DATA_W-1:0]                      resp_data;
  logic                                   resp_ready;

  modport master (
    output req_valid, req_cmd, req_addr, req_tag, req_data, req_byte_en, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_tag, req_data, req_byte_en, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data
  );
endinterface

// File: rtl/tb_l2_mem_responder.sv
// Line-array memory responder: byte-enabled writes, in-order tagged reads after a fixed latency.
// Optional macro TB_L2_MEM_RESP_RANDOM_STALL_EN adds LFSR-driven request back-pressure.
module tb_l2_mem_responder
  import tb_l2_mem_responder_pkg::*;
#(
  parameter int          DATA_W     = 128,
  parameter int          ADDR_W     = 32,
  parameter int          TAG_W      = 4,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          MEM_LINES  = 4096,
  parameter int          RD_LATENCY = 4,
  parameter int          RESP_DEPTH = 4
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  tb_l2_mem_responder_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A   = BASE_ADDR[ADDR_W-1:0];
  localparam logic [63:0]       LIMIT_64 = BASE_ADDR + 64'(MEM_LINES) * 64'(BYTES);
  localparam logic [ADDR_W:0]   LIMIT_X  = LIMIT_64[ADDR_W:0];

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rd_ent_t;

  logic [DATA_W-1:0]       mem_q [MEM_LINES];
  logic [TAG_W+DATA_W-1:0] fifo_q [RESP_DEPTH];

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              req_ready;
  logic              req_acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              resp_valid;
  logic              resp_hs;
  logic              stall;
  rd_ent_t           acc_ent;
  rd_ent_t           fifo_in;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_q, out_d;

`ifdef TB_L2_MEM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
  assign req_ready = i_reset_n && (out_q < DEPTH_C) && !stall;
  assign req_acc   = bus.req_valid && req_ready;

  always_comb begin
    in_range = (bus.req_addr >= BASE_A) && ({1'b0, bus.req_addr} < LIMIT_X);
    off      = bus.req_addr - BASE_A;
    idx      = IDX_W'(off >> OFF_W);
    rd_acc   = req_acc && (bus.req_cmd == M_XRD);
    wr_acc   = req_acc && (bus.req_cmd == M_XWR) && in_range;
    acc_ent.vld  = rd_acc;
    acc_ent.tag  = bus.req_tag;
    acc_ent.data = in_range ? mem_q[idx] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_byte_en[b]) begin
          mem_q[idx][b*8 +: 8] <= bus.req_data[b*8 +: 8];
        end
      end
    end
  end

  // The FIFO write is the last latency stage, so only RD_LATENCY-1 registers precede it.
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      rd_ent_t pipe_q [RD_LATENCY-1];
      rd_ent_t pipe_d [RD_LATENCY-1];

      always_comb begin
        pipe_d[0] = acc_ent;
        for (int i = 1; i < RD_LATENCY - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge i_clk) begin
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
          if (!i_reset_n) begin
            pipe_q[i] <= '0;
          end else begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign fifo_in = pipe_q[RD_LATENCY-2];
    end else begin : g_nopipe
      assign fifo_in = acc_ent;
    end
  endgenerate

  assign resp_valid = (cnt_q != '0);
  assign resp_hs    = resp_valid && bus.resp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_in.vld) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (resp_hs) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(fifo_in.vld) - CNT_W'(resp_hs);
    out_d = out_q + CNT_W'(rd_acc) - CNT_W'(resp_hs);
  end

  always_ff @(posedge i_clk) begin
    if (fifo_in.vld) begin
      fifo_q[wr_ptr_q] <= {fifo_in.tag, fifo_in.data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  // Head is masked to zero when empty so idle/reset outputs read as all-zero.
  assign bus.req_ready                  = req_ready;
  assign bus.resp_valid                 = resp_valid;
  assign {bus.resp_tag, bus.resp_data}  = resp_valid ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_tb_l2_mem_responder.sv
// Bench for tb_l2_mem_responder: directed plan steps plus a random phase,
// checked against a line-array/queue reference model.
module tb_tb_l2_mem_responder;
  import tb_l2_mem_responder_pkg::*;

  localparam int          DATA_W  = 128;
  localparam int          ADDR_W  = 32;
  localparam int          TAG_W   = 4;
  localparam int          LAT     = 4;
  localparam int          DEPTH   = 4;
  localparam int          LINES   = 4096;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam logic [63:0] LINE_B  = 64'd16;
  localparam logic [63:0] LIMIT   = BASE + 64'(LINES) * LINE_B;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   resp_seen;
  int   reads_acc;
  bit   rand_ready;

  logic [DATA_W-1:0]       model_mem [int];
  logic [TAG_W+DATA_W-1:0] exp_q [$];

  tb_l2_mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  tb_l2_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .BASE_ADDR(BASE),
    .MEM_LINES(LINES), .RD_LATENCY(LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [131:0] obs, input logic [131:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_accept();
    logic [63:0]       a;
    logic              in_r;
    int                idx;
    logic [DATA_W-1:0] line;
    a    = {32'b0, bus.req_addr};
    in_r = (a >= BASE) && (a < LIMIT);
    idx  = in_r ? int'((a - BASE) / LINE_B) : 0;
    if (bus.req_cmd == M_XWR && in_r) begin
      line = model_mem.exists(idx) ? model_mem[idx] : '0;
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (bus.req_byte_en[b]) line[b*8 +: 8] = bus.req_data[b*8 +: 8];
      end
      model_mem[idx] = line;
    end else if (bus.req_cmd == M_XRD) begin
      line = (in_r && model_mem.exists(idx)) ? model_mem[idx] : '0;
      exp_q.push_back({bus.req_tag, line});
      reads_acc++;
    end
  endtask

  // One clock: evaluate handshakes just before the edge, then land #1 after it.
  task automatic tick(output logic acc);
    logic                    hs;
    logic                    hold;
    logic [TAG_W+DATA_W-1:0] held;
    logic [TAG_W+DATA_W-1:0] front;
    #1;
    if (rand_ready) bus.resp_ready = ($urandom_range(0, 3) != 0);
    acc  = bus.req_valid && bus.req_ready;
    hs   = bus.resp_valid && bus.resp_ready;
    hold = bus.resp_valid && !bus.resp_ready;
    held = {bus.resp_tag, bus.resp_data};
    if (hs) begin
      resp_seen++;
      check_output("resp_vs_model", 132'(bus.resp_valid), 132'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        check_output("resp_tag", 132'(bus.resp_tag), 132'(front[TAG_W+DATA_W-1:DATA_W]));
        check_output("resp_data", 132'(bus.resp_data), 132'(front[DATA_W-1:0]));
      end
    end
    if (acc) model_accept();
    @(posedge clk);
    #1;
    if (hold && rst_n) begin
      check_output("hold_valid", 132'(bus.resp_valid), 132'(1));
      check_output("hold_payload", 132'({bus.resp_tag, bus.resp_data}), 132'(held));
    end
  endtask

  task automatic apply_stimulus(input mem_cmd_t cmd, input logic [31:0] addr, input logic [3:0] tag,
                                input logic [127:0] data, input logic [15:0] be);
    logic acc;
    int   n;
    bus.req_valid   = 1'b1;
    bus.req_cmd     = cmd;
    bus.req_addr    = addr;
    bus.req_tag     = tag;
    bus.req_data    = data;
    bus.req_byte_en = be;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    check_output("req_accept", 132'(acc), 132'(1));
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 500) begin
      tick(acc);
      n++;
    end
    repeat (6) tick(acc);
    check_output("drain_empty", 132'(exp_q.size()), 132'(0));
  endtask

  // Issue a read into an idle responder and check latency plus the literal expected line.
  task automatic read_expect(input logic [31:0] addr, input logic [3:0] tag, input logic [127:0] exp);
    logic acc;
    int   n;
    apply_stimulus(M_XRD, addr, tag, '0, '0);
    n = 1;
    while (!bus.resp_valid && n < 50) begin
      tick(acc);
      n++;
    end
    check_output("rd_latency", 132'(n), 132'(LAT));
    check_output("rd_tag_direct", 132'(bus.resp_tag), 132'(tag));
    check_output("rd_data_direct", 132'(bus.resp_data), 132'(exp));
    drain();
  endtask

  initial begin
    logic         acc;
    logic         any_acc;
    logic [127:0] line0;
    logic [127:0] x1;
    logic [127:0] x2;
    logic [31:0]  addr;
    int           sel;
    int           n;

    checks = 0; errors = 0; resp_seen = 0; reads_acc = 0; rand_ready = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_cmd = M_XRD; bus.req_addr = '0; bus.req_tag = '0;
    bus.req_data = '0; bus.req_byte_en = '0; bus.resp_ready = 1'b1;

    repeat (3) tick(acc);
    check_output("rst_req_ready", 132'(bus.req_ready), 132'(0));
    check_output("rst_resp_valid", 132'(bus.resp_valid), 132'(0));
    check_output("rst_resp_tag", 132'(bus.resp_tag), 132'(0));
    check_output("rst_resp_data", 132'(bus.resp_data), 132'(0));
    rst_n = 1'b1;
    #1;
    check_output("ready_after_rst", 132'(bus.req_ready), 132'(1));

    apply_stimulus(M_XWR, 32'h8000_0040, 4'd0, {16{8'hA5}}, 16'hFFFF);
    read_expect(32'h8000_0040, 4'd3, {16{8'hA5}});

    apply_stimulus(M_XWR, 32'h8000_0080, 4'd0, {16{8'hFF}}, 16'hFFFF);
    apply_stimulus(M_XWR, 32'h8000_0080, 4'd0, {$urandom, $urandom, $urandom, 32'h1122_3344}, 16'h000F);
    read_expect(32'h8000_0080, 4'd5, {{12{8'hFF}}, 32'h1122_3344});

    line0 = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(M_XWR, 32'h8000_0000, 4'd0, line0, 16'hFFFF);
    read_expect(32'h7FFF_FFC0, 4'd6, 128'd0);
    apply_stimulus(M_XWR, 32'h8001_0000, 4'd0, {16{8'h5A}}, 16'hFFFF);
    read_expect(32'h8000_0000, 4'd7, line0);
    apply_stimulus(M_XWR, 32'h8000_FFF0, 4'd0, {16{8'h3C}}, 16'hFFFF);
    read_expect(32'h8000_FFF8, 4'd8, {16{8'h3C}});

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(M_XWR, 32'h8000_0100 + 32'(16 * i), 4'd0, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    end
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_cmd    = M_XRD;
    for (int t = 0; t < 4; t++) begin
      bus.req_tag  = 4'(t);
      bus.req_addr = 32'h8000_0100 + 32'(16 * t);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
        tick(acc);
        n++;
      end
      check_output("credit_accept", 132'(acc), 132'(1));
    end
    check_output("full_ready_low", 132'(bus.req_ready), 132'(0));
    bus.req_tag  = 4'd4;
    bus.req_addr = 32'h8000_0140;
    any_acc = 1'b0;
    repeat (10) begin
      tick(acc);
      any_acc = any_acc | acc;
    end
    check_output("full_no_accept", 132'(any_acc), 132'(0));
    check_output("full_ready_held", 132'(bus.req_ready), 132'(0));
    check_output("full_resp_valid", 132'(bus.resp_valid), 132'(1));
    bus.resp_ready = 1'b1;
    tick(acc);
    check_output("release_no_accept", 132'(acc), 132'(0));
    check_output("ready_after_hs", 132'(bus.req_ready), 132'(1));
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    check_output("tag4_accept", 132'(acc), 132'(1));
    apply_stimulus(M_XRD, 32'h8000_0150, 4'd5, '0, '0);
    drain();

    x1 = {$urandom, $urandom, $urandom, $urandom};
    x2 = ~x1;
    apply_stimulus(M_XWR, 32'h8000_0200, 4'd0, x1, 16'hFFFF);
    apply_stimulus(M_XRD, 32'h8000_0200, 4'd8, '0, '0);
    apply_stimulus(M_XWR, 32'h8000_0200, 4'd0, x2, 16'hFFFF);
    drain();
    read_expect(32'h8000_0200, 4'd9, x2);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(M_XRD, 32'h8000_0040, 4'(10 + i), '0, '0);
    end
    rst_n = 1'b0;
    reads_acc -= exp_q.size();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check_output("rst_flight_valid", 132'(bus.resp_valid), 132'(0));
    end
    rst_n = 1'b1;
    #1;
    check_output("ready_after_rst2", 132'(bus.req_ready), 132'(1));
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      check_output("post_rst_valid", 132'(bus.resp_valid), 132'(0));
    end
    read_expect(32'h8000_0040, 4'd13, {16{8'hA5}});

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(M_XWR, 32'h8000_0400 + 32'(16 * i), 4'd0, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    end
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) tick(acc);
      sel  = $urandom_range(0, 99);
      addr = 32'h8000_0400 + 32'(16 * $urandom_range(0, 7)) + 32'($urandom_range(0, 15));
      if (sel < 45) begin
        apply_stimulus(M_XRD, addr, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      end else if (sel < 80) begin
        apply_stimulus(M_XWR, addr, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      end else if (sel < 88) begin
        apply_stimulus(M_PFR, addr, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      end else begin
        addr = ($urandom_range(0, 1) == 1) ? 32'h8001_0000 + 32'($urandom_range(0, 4095))
                                           : 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
        apply_stimulus((sel < 94) ? M_XRD : M_XWR, addr, 4'($urandom),
                       {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      end
    end
    rand_ready     = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
    check_output("resp_count", 132'(resp_seen), 132'(reads_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
